// File: rtl/message_channel_arbiter.sv
// Round-robin merge of N_SRC tagged message sources onto one valid/ready
// channel, with in-flight status and a sent-word counter.
module message_channel_arbiter #(
    parameter int WIDTH    = 128,
    parameter int N_SRC    = 4,
    parameter int SRC_ID_W = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                enable,
    input  logic [N_SRC*(WIDTH-SRC_ID_W)-1:0]   src_data,
    input  logic [N_SRC-1:0]                    src_valid,
    output logic [N_SRC-1:0]                    src_ready,
    output logic [WIDTH-1:0]                    out_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                has_message_flying,
    output logic [31:0]                         sent_count
);

    localparam int P = WIDTH - SRC_ID_W;
    localparam int SW = SRC_ID_W + 1;

    logic [SRC_ID_W-1:0] r_rr_ptr;
    logic                r_out_valid;
    logic [WIDTH-1:0]    r_out_data;
    logic                r_flying;
    logic [31:0]         r_sent_count;

    logic                w_load_en;
    logic                w_gnt_vld;
    logic                w_grant;
    logic                w_accept;
    logic                w_out_valid_nxt;
    logic [SRC_ID_W-1:0] w_gnt_idx;
    logic [SRC_ID_W-1:0] w_rr_nxt;
    logic [SW-1:0]       w_scan;
    logic [P-1:0]        w_payload [N_SRC];

    for (genvar k = 0; k < N_SRC; k++) begin : g_pay
        assign w_payload[k] = src_data[k*P +: P];
    end

    assign w_load_en = enable && (!r_out_valid || out_ready);

    // Walk the scan order backwards so the first valid source after
    // the pointer is the last one written and therefore wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_scan    = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            w_scan = {1'b0, r_rr_ptr} + SW'(i);
            if (w_scan >= SW'(N_SRC)) begin
                w_scan = w_scan - SW'(N_SRC);
            end
            if (src_valid[w_scan[SRC_ID_W-1:0]]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_scan[SRC_ID_W-1:0];
            end
        end
    end

    assign w_grant  = reset && w_load_en && w_gnt_vld;
    assign w_accept = r_out_valid && out_ready;

    assign w_out_valid_nxt = w_grant || (r_out_valid && !out_ready);

    assign w_rr_nxt = (w_gnt_idx == SRC_ID_W'(N_SRC - 1)) ?
                      '0 : w_gnt_idx + 1'b1;

    always_comb begin
        src_ready = '0;
        if (w_grant) begin
            src_ready[w_gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_rr_ptr    <= '0;
        end else begin
            r_out_valid <= w_out_valid_nxt;
            if (w_grant) begin
                r_out_data <= {w_gnt_idx, w_payload[w_gnt_idx]};
                r_rr_ptr   <= w_rr_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flying     <= 1'b0;
            r_sent_count <= '0;
        end else begin
            r_flying <= (|src_valid) || w_out_valid_nxt;
            if (w_accept) begin
                r_sent_count <= r_sent_count + 32'd1;
            end
        end
    end

    assign out_data           = r_out_data;
    assign out_valid          = r_out_valid;
    assign has_message_flying = r_flying;
    assign sent_count         = r_sent_count;

endmodule

// File: tb/tb_message_channel_arbiter.sv
// Directed and randomized checks of message_channel_arbiter against a
// cycle-level reference model of the round-robin channel merge.
module tb_message_channel_arbiter;

    localparam int W   = 128;
    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int P   = W - IDW;

    logic           clk = 1'b0;
    logic           reset;
    logic           enable;
    logic [N*P-1:0] src_data;
    logic [N-1:0]   src_valid;
    logic [N-1:0]   src_ready;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic           flying;
    logic [31:0]    sent_count;

    int n_pass  = 0;
    int n_total = 0;

    int          m_rr;
    logic        m_ov;
    logic [W-1:0] m_od;
    logic        m_fly;
    logic [31:0] m_cnt;
    int          g_k;
    logic [N-1:0] exp_ready;

    message_channel_arbiter #(
        .WIDTH(W), .N_SRC(N), .SRC_ID_W(IDW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .src_data(src_data),
        .src_valid(src_valid),
        .src_ready(src_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .has_message_flying(flying),
        .sent_count(sent_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [P-1:0] rnd_payload();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[P-1:0];
    endfunction

    task automatic set_src(input int k, input logic [P-1:0] pl);
        src_data[k*P +: P] = pl;
        src_valid[k] = 1'b1;
    endtask

    task automatic model_reset();
        m_rr = 0; m_ov = 1'b0; m_od = '0; m_fly = 1'b0; m_cnt = '0;
    endtask

    // Grant: first valid source scanning from the pointer, if a load is allowed.
    task automatic model_comb();
        int k;
        g_k = -1;
        exp_ready = '0;
        if (enable && (!m_ov || out_ready)) begin
            for (int i = 0; i < N; i++) begin
                k = (m_rr + i) % N;
                if (src_valid[k] && g_k < 0) g_k = k;
            end
        end
        if (g_k >= 0) exp_ready[g_k] = 1'b1;
    endtask

    task automatic model_seq();
        if (m_ov && out_ready) m_cnt = m_cnt + 32'd1;
        if (g_k >= 0) begin
            m_od = {IDW'(g_k), src_data[g_k*P +: P]};
            m_ov = 1'b1;
            m_rr = (g_k + 1) % N;
        end else if (m_ov && out_ready) begin
            m_ov = 1'b0;
        end
        m_fly = (|src_valid) || m_ov;
    endtask

    task automatic cycle();
        #1;
        model_comb();
        chk("src_ready", W'(src_ready), W'(exp_ready));
        @(posedge clk);
        model_seq();
        @(negedge clk);
        chk("out_valid", W'(out_valid), W'(m_ov));
        chk("out_data", out_data, m_od);
        chk("flying", W'(flying), W'(m_fly));
        chk("sent_count", W'(sent_count), W'(m_cnt));
    endtask

    task automatic retire(input bit refill);
        if (g_k >= 0) begin
            if (refill) src_data[g_k*P +: P] = rnd_payload();
            else src_valid[g_k] = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_reset();
        chk("rst_out_valid", W'(out_valid), '0);
        chk("rst_out_data", out_data, '0);
        chk("rst_flying", W'(flying), '0);
        chk("rst_sent", W'(sent_count), '0);
        chk("rst_src_ready", W'(src_ready), '0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; out_ready = 1'b1;
        src_valid = '0; src_data = '0;
        model_reset();
        @(negedge clk);
        do_reset();

        // single source 2
        set_src(2, P'(8'h5A));
        cycle();
        chk("t1_tag", W'(out_data[W-1 -: IDW]), W'(2));
        chk("t1_payload", W'(out_data[P-1:0]), W'(8'h5A));
        retire(1'b0);
        cycle();
        chk("t1_sent", W'(sent_count), W'(1));

        // all sources valid: strict rotation from source 0
        do_reset();
        for (int k = 0; k < N; k++) set_src(k, rnd_payload());
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("t2_tag", W'(out_data[W-1 -: IDW]), W'(i % N));
            retire(1'b1);
        end
        src_valid = '0;
        cycle();
        chk("t2_sent8", W'(sent_count), W'(8));

        // backpressure
        for (int k = 0; k < N; k++) set_src(k, rnd_payload());
        cycle();
        retire(1'b1);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t3_stall_ready", W'(src_ready), '0);
        end
        out_ready = 1'b1;
        cycle();
        retire(1'b1);

        // enable pause with sources 1 and 3 pending
        src_valid = 4'b1010;
        enable = 1'b0;
        cycle();
        chk("t4_drained", W'(out_valid), '0);
        cycle();
        enable = 1'b1;
        cycle();
        retire(1'b0);
        cycle();
        retire(1'b0);
        cycle();

        // has_message_flying lifetime
        do_reset();
        set_src(0, rnd_payload());
        cycle();
        retire(1'b0);
        for (int i = 0; i < 3; i++) cycle();
        chk("t5_flying_low", W'(flying), '0);

        // async reset during a stall
        for (int k = 0; k < N; k++) set_src(k, rnd_payload());
        out_ready = 1'b0;
        cycle();
        cycle();
        do_reset();
        out_ready = 1'b1;
        src_valid = 4'b1001;
        cycle();
        chk("t6_first_src0", W'(out_data[W-1 -: IDW]), W'(0));
        retire(1'b0);
        cycle();
        retire(1'b0);
        src_valid = '0;
        cycle();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            enable    = ($urandom_range(0, 9) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            for (int k = 0; k < N; k++) begin
                if (!src_valid[k] && $urandom_range(0, 3) == 0)
                    set_src(k, rnd_payload());
            end
            cycle();
            retire(1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/message_channel_arbiter.md
Name: message_channel_arbiter

Overview:
Sits directly upstream of the inter-FPGA interconnection channel. It merges N_SRC local message sources (boundary PE groups) onto one WIDTH-bit valid/ready channel that feeds one upstream_fifo_in lane. Arbitration is round-robin, and the source index is tagged into each word. The block also produces the per-channel has_message_flying status and a sent-message count.

Parameters:
WIDTH, 128, channel word width (tag + payload)
N_SRC, 4, number of local sources (2..16)
SRC_ID_W, 2, tag width; must equal max(1, clog2(N_SRC))

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (reset==0 clears all state immediately)
enable  input  1  1 = grants allowed; 0 = no new grants, output register drains
src_data  input  N_SRC*(WIDTH-SRC_ID_W)  payload of source k at bits [(k+1)*P-1 : k*P], where P = WIDTH-SRC_ID_W
src_valid  input  N_SRC  source k holds a word
src_ready  output  N_SRC  combinational grant; source k's word is consumed this cycle
out_data  output  WIDTH  registered word {src_id, payload}; src_id in the top SRC_ID_W bits
out_valid  output  1  registered; out_data is valid
out_ready  input  1  channel accepts the word (connects to the interconnect lane's in_ready)
has_message_flying  output  1  registered; any source or the output register holds a pending word
sent_count  output  32  number of words accepted by the channel; wraps modulo 2^32

Behaviour:
- Reset (reset==0, async): out_valid=0, out_data=0, rr_ptr=0, has_message_flying=0, sent_count=0. src_ready is 0 while reset is asserted.
- load_en = enable && (!out_valid || out_ready). A word may load in the same cycle the previous one leaves, giving full throughput of one word/cycle.
- Arbitration:
  - If load_en is high, scan k = rr_ptr, rr_ptr+1, … mod N_SRC. The first k with src_valid[k]=1 is granted: src_ready[k]=1, and all other src_ready bits are 0.
  - If load_en is low, or no source is valid, all src_ready bits are 0.
- On a grant to k, at the next edge:
  - out_data <= {k[SRC_ID_W-1:0], payload_k}
  - out_valid <= 1
  - rr_ptr <= (k+1) mod N_SRC
- If out_valid && out_ready and there is no grant: out_valid <= 0 at the next edge. out_data holds its last value and rr_ptr is unchanged.
- If out_valid && !out_ready: out_data and out_valid hold, with no grant (stall).
- Latency: src_valid&&src_ready at edge N gives out_valid=1 with that word in the cycle after edge N.
- enable deassert mid-stream: a word already in the output register still completes normally. No new grant occurs until enable returns to 1. rr_ptr is preserved across the pause.
- has_message_flying <= (|src_valid) || out_valid_next, updated every edge. out_valid_next is the value out_valid takes at the same edge. The output drops only one cycle after the last word is accepted and all src_valid bits are 0.
- sent_count increments by 1 on each edge where out_valid && out_ready. 0xFFFFFFFF wraps to 0.
- Sources must hold src_valid and data stable until granted. The arbiter never drops or duplicates a word.
- Reset asserted mid-transfer: a word held in the output register is discarded. After reset release the next grant starts scanning from source 0.

Test Plan:
- Single source: N_SRC=4, source 2 sends payload 0x5A, out_ready=1 -> src_ready[2]=1 for one cycle. Next cycle: out_valid=1, out_data top 2 bits=2'b10, low bits=0x5A. sent_count becomes 1.
- All four sources continuously valid, out_ready=1 -> grants in order 0,1,2,3,0,1…, one per cycle. out_data tags follow 0,1,2,3, with no idle cycle. sent_count=8 after 8 transfers.
- Backpressure: out_ready=0 for 5 cycles with out_valid=1 -> out_data stays stable and src_ready=0 throughout. Raising out_ready releases the held word and loads the next grant in the same cycle.
- enable=0 while the output holds a word and sources 1 and 3 are valid -> the held word drains, then out_valid=0 and no grants. Re-enable -> the scan resumes from the saved rr_ptr.
- has_message_flying: one word from source 0, then all sources idle -> the flag is 1 from the cycle after src_valid rises until one cycle after acceptance, then 0.
- Async reset pulse mid-stall: reset low between edges -> out_valid, has_message_flying, and sent_count read 0 immediately. After release, source 3 and source 0 both valid -> source 0 is granted first.
